// File: rtl/usb_rx_packetizer_if.sv
`timescale 1ns/1ps
// Packet-buffer write port and receive status of the USB RX packetizer.
// master: driven by the packetizer (buffer word address/value/strobe, got_packet,
// packet_length, packet_error, busy). slave: the buffer / packet-ready logic.
interface usb_rx_packetizer_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int LENGTH_WIDTH  = 11
);
    logic [ADDRESS_WIDTH-1:0] buffer_address;
    logic [31:0]              buffer_write_value;
    logic                     buffer_write;
    logic                     got_packet;
    logic [LENGTH_WIDTH-1:0]  packet_length;
    logic                     packet_error;
    logic                     busy;

    modport master (
        output buffer_address, buffer_write_value, buffer_write,
        output got_packet, packet_length, packet_error, busy
    );

    modport slave (
        input buffer_address, buffer_write_value, buffer_write,
        input got_packet, packet_length, packet_error, busy
    );
endinterface

// File: rtl/usb_rx_packetizer.sv
`timescale 1ns/1ps
// Full-speed USB receiver: 4x oversampled clock recovery, NRZI decode, unstuffing,
// SYNC/EOP detection; packs bytes little-endian into 32-bit buffer writes.
// Latency: a word is written 1 cycle after its last bit sample; no backpressure.
// Ports: clk48, reset (async, active high), d_p/d_n raw pads, enable; pkt = buffer
// write port (address, value, strobe) plus got_packet/packet_length/packet_error/busy.
module usb_rx_packetizer #(
    parameter int BUFFER_WORDS  = 256,
    parameter int ADDRESS_WIDTH = 8,
    parameter int LENGTH_WIDTH  = 11
) (
    input  logic                clk48,
    input  logic                reset,
    input  logic                d_p,
    input  logic                d_n,
    input  logic                enable,
    usb_rx_packetizer_if.master pkt
);
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam logic [LENGTH_WIDTH-1:0] MAX_BYTES = LENGTH_WIDTH'(BUFFER_WORDS * 4);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_DATA, ST_EOP, ST_DONE, ST_ERROR
    } state_t;

    state_t state, state_n;

    logic dp_meta, dp_sync, dn_meta, dn_sync;
    logic [1:0] line_q, line_now, prev_samp;
    logic [1:0] phase;
    logic       sample, bit_one, se0;

    logic [1:0]              zero_cnt;
    logic [2:0]              stuff_cnt;
    logic [2:0]              bit_cnt;
    logic [6:0]              shift_q;
    logic [LENGTH_WIDTH-1:0] byte_cnt;
    logic [31:0]             word_q, merged;
    logic [7:0]              new_byte;
    logic                    se0_seen, err_q;
    logic                    write_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [31:0]             value_q;
    logic [LENGTH_WIDTH-1:0] length_q;

    logic in_data, data_bit, stuff_drop, stuff_bad, byte_done, overflow, eop_ok, eop_bad;

    // SE1 is not a legal line state; hold the last legal one instead.
    assign line_now = ({dp_sync, dn_sync} == LS_SE1) ? line_q : {dp_sync, dn_sync};
    // Phase restarts at every line transition, so phase 2 is mid-bit.
    assign sample   = (phase == 2'd2);
    assign bit_one  = (line_q == prev_samp);
    assign se0      = (line_q == LS_SE0);

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            dp_meta   <= 1'b1;
            dp_sync   <= 1'b1;
            dn_meta   <= 1'b0;
            dn_sync   <= 1'b0;
            line_q    <= LS_J;
            phase     <= 2'd0;
            prev_samp <= LS_J;
        end else begin
            dp_meta <= d_p;
            dp_sync <= dp_meta;
            dn_meta <= d_n;
            dn_sync <= dn_meta;
            line_q  <= line_now;
            phase   <= (line_now != line_q) ? 2'd0 : phase + 2'd1;
            if (sample) prev_samp <= line_q;
        end
    end

    assign in_data    = sample && (state == ST_DATA) && enable;
    // After six 1s the next bit is a stuffed 0 and never reaches the shifter.
    assign data_bit   = in_data && !se0 && (stuff_cnt != 3'd6);
    assign stuff_drop = in_data && !se0 && (stuff_cnt == 3'd6) && !bit_one;
    assign stuff_bad  = in_data && !se0 && (stuff_cnt == 3'd6) && bit_one;
    assign byte_done  = data_bit && (bit_cnt == 3'd7);
    assign overflow   = byte_done && (byte_cnt == MAX_BYTES);
    assign eop_ok     = in_data && se0 && (bit_cnt == 3'd0) && (byte_cnt != '0);
    assign eop_bad    = in_data && se0 && !((bit_cnt == 3'd0) && (byte_cnt != '0));
    assign new_byte   = {bit_one, shift_q};

    always_comb begin
        merged = word_q;
        case (byte_cnt[1:0])
            2'd0:    merged[7:0]   = new_byte;
            2'd1:    merged[15:8]  = new_byte;
            2'd2:    merged[23:16] = new_byte;
            default: merged[31:24] = new_byte;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_n;
    end

    // FSM: next state
    always_comb begin
        state_n = state;
        if (!enable) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (sample && line_q == LS_K) state_n = ST_SYNC;
                ST_SYNC: begin
                    if (sample) begin
                        if (se0)          state_n = ST_IDLE;
                        else if (bit_one) state_n = (zero_cnt == 2'd3) ? ST_DATA : ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (stuff_bad || overflow || eop_bad) state_n = ST_ERROR;
                    else if (eop_ok)                      state_n = ST_EOP;
                end
                ST_EOP: begin
                    if (sample) begin
                        if (line_q == LS_J) state_n = ST_DONE;
                        else if (!se0)      state_n = ST_ERROR;
                    end
                end
                ST_DONE:  state_n = ST_IDLE;
                ST_ERROR: if (sample && line_q == LS_J && se0_seen) state_n = ST_IDLE;
                default:  state_n = ST_IDLE;
            endcase
        end
    end

    // FSM: outputs
    always_comb begin
        pkt.busy         = (state != ST_IDLE);
        pkt.got_packet   = (state == ST_DONE) && enable;
        pkt.packet_error = (state == ST_ERROR) && !err_q && enable;
    end

    assign pkt.buffer_write       = write_q;
    assign pkt.buffer_address     = addr_q;
    assign pkt.buffer_write_value = value_q;
    assign pkt.packet_length      = length_q;

    always_ff @(posedge clk48 or posedge reset) begin
        if (reset) begin
            zero_cnt  <= 2'd0;
            stuff_cnt <= 3'd0;
            bit_cnt   <= 3'd0;
            shift_q   <= 7'd0;
            byte_cnt  <= '0;
            word_q    <= 32'd0;
            se0_seen  <= 1'b0;
            err_q     <= 1'b0;
            write_q   <= 1'b0;
            addr_q    <= '0;
            value_q   <= 32'd0;
            length_q  <= '0;
        end else begin
            write_q <= 1'b0;
            err_q   <= (state == ST_ERROR);

            if (state == ST_IDLE) zero_cnt <= 2'd0;
            else if (state == ST_SYNC && sample && !bit_one && zero_cnt != 2'd3)
                zero_cnt <= zero_cnt + 2'd1;

            if (state == ST_SYNC && state_n == ST_DATA) begin
                stuff_cnt <= 3'd0;
                bit_cnt   <= 3'd0;
                byte_cnt  <= '0;
                word_q    <= 32'd0;
            end

            if (stuff_drop) stuff_cnt <= 3'd0;

            if (data_bit) begin
                stuff_cnt <= bit_one ? stuff_cnt + 3'd1 : 3'd0;
                shift_q   <= {bit_one, shift_q[6:1]};
                bit_cnt   <= bit_cnt + 3'd1;
            end

            if (byte_done && !overflow) begin
                byte_cnt <= byte_cnt + LENGTH_WIDTH'(1);
                if (byte_cnt[1:0] == 2'd3) begin
                    write_q <= 1'b1;
                    addr_q  <= byte_cnt[ADDRESS_WIDTH+1:2];
                    value_q <= merged;
                    word_q  <= 32'd0;
                end else begin
                    word_q <= merged;
                end
            end

            // Flush a partly filled word; unfilled upper lanes are already zero.
            if (eop_ok) begin
                length_q <= byte_cnt;
                if (byte_cnt[1:0] != 2'd0) begin
                    write_q <= 1'b1;
                    addr_q  <= byte_cnt[ADDRESS_WIDTH+1:2];
                    value_q <= word_q;
                end
            end

            if (state != ST_ERROR)  se0_seen <= 1'b0;
            else if (sample && se0) se0_seen <= 1'b1;
        end
    end
endmodule

// File: tb/tb_usb_rx_packetizer.sv
`timescale 1ns/1ps
// Bench for usb_rx_packetizer: NRZI/bit-stuffing line encoder drives d_p/d_n,
// a byte-level model predicts buffer writes and packet outcome, and one monitor
// compares every write/pulse against it; literal checks pin the model.
module tb_usb_rx_packetizer;
    localparam int BUFFER_WORDS  = 256;
    localparam int ADDRESS_WIDTH = 8;
    localparam int LENGTH_WIDTH  = 11;
    localparam logic [1:0] LS_J   = 2'b10;
    localparam logic [1:0] LS_K   = 2'b01;
    localparam logic [1:0] LS_SE0 = 2'b00;

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [31:0]              val;
    } wr_t;

    logic clk48 = 1'b0;
    logic reset, d_p, d_n, enable;

    usb_rx_packetizer_if #(.ADDRESS_WIDTH(ADDRESS_WIDTH), .LENGTH_WIDTH(LENGTH_WIDTH)) bus();

    usb_rx_packetizer #(
        .BUFFER_WORDS(BUFFER_WORDS), .ADDRESS_WIDTH(ADDRESS_WIDTH), .LENGTH_WIDTH(LENGTH_WIDTH)
    ) dut (
        .clk48(clk48), .reset(reset), .d_p(d_p), .d_n(d_n), .enable(enable), .pkt(bus)
    );

    always #10 clk48 = ~clk48;

    int checks = 0;
    int errors = 0;
    wr_t exp_q[$];
    wr_t log_q[$];
    wr_t cmp_e;
    int  got_cnt, err_cnt, exp_got, exp_err;
    logic [LENGTH_WIDTH-1:0] exp_len;

    logic [1:0] tx_line;
    int         tx_bitn;
    bit         tx_jit;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] logv(input int i);
        return (i < log_q.size()) ? log_q[i].val : 32'hDEADBEEF;
    endfunction

    // Monitor: every write strobe and pulse is checked against the model.
    always @(posedge clk48) begin
        #1;
        if (bus.buffer_write === 1'b1) begin
            log_q.push_back('{addr: bus.buffer_address, val: bus.buffer_write_value});
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                cmp_e = exp_q.pop_front();
                chk("write_addr", 32'(bus.buffer_address), 32'(cmp_e.addr));
                chk("write_value", bus.buffer_write_value, cmp_e.val);
            end
        end
        if (bus.got_packet === 1'b1) begin
            got_cnt++;
            chk("got_length", 32'(bus.packet_length), 32'(exp_len));
        end
        if (bus.packet_error === 1'b1) err_cnt++;
    end

    // Byte-level model: which words land where, and how the packet ends.
    task automatic build_model(input byte_q_t bytes, input bit nostuff, input int abort_byte);
        int usable;
        int ones;
        logic [31:0] word;
        usable  = bytes.size();
        exp_got = 1;
        exp_err = 0;
        if (abort_byte >= 0) begin
            usable  = abort_byte;
            exp_got = 0;
        end
        if (nostuff) begin
            ones = 0;
            for (int k = 0; k < usable * 8; k++) begin
                if (bytes[k / 8][k % 8]) ones++;
                else ones = 0;
                if (ones == 7) begin
                    usable  = k / 8;
                    exp_err = 1;
                    exp_got = 0;
                    break;
                end
            end
        end
        if (usable > BUFFER_WORDS * 4) begin
            usable  = BUFFER_WORDS * 4;
            exp_err = 1;
            exp_got = 0;
        end
        word = 32'd0;
        for (int n = 0; n < usable; n++) begin
            word = word | (32'(bytes[n]) << (8 * (n % 4)));
            if (n % 4 == 3) begin
                exp_q.push_back('{addr: ADDRESS_WIDTH'(n / 4), val: word});
                word = 32'd0;
            end
        end
        if (exp_got == 1 && usable % 4 != 0)
            exp_q.push_back('{addr: ADDRESS_WIDTH'(usable / 4), val: word});
        exp_len = LENGTH_WIDTH'(usable);
    endtask

    task automatic drive(input logic [1:0] st, input int cyc);
        d_p = st[1];
        d_n = st[0];
        repeat (cyc) @(negedge clk48);
    endtask

    task automatic tx_bit(input bit b);
        if (!b) tx_line = (tx_line == LS_J) ? LS_K : LS_J;
        drive(tx_line, tx_jit ? ((tx_bitn % 2 == 1) ? 5 : 3) : 4);
        tx_bitn++;
    endtask

    task automatic do_abort(input int kind);
        if (kind == 0) begin
            reset = 1'b1;
            #1;
            chk("abort_reset_write", 32'(bus.buffer_write), 32'd0);
            chk("abort_reset_busy", 32'(bus.busy), 32'd0);
            chk("abort_reset_addr", 32'(bus.buffer_address), 32'd0);
            chk("abort_reset_value", bus.buffer_write_value, 32'd0);
            chk("abort_reset_length", 32'(bus.packet_length), 32'd0);
            drive(LS_J, 4);
            reset = 1'b0;
            drive(LS_J, 8);
        end else begin
            enable = 1'b0;
            @(posedge clk48);
            #1;
            chk("abort_enable_idle", 32'(bus.busy), 32'd0);
            @(negedge clk48);
            drive(LS_J, 8);
            enable = 1'b1;
            drive(LS_J, 8);
        end
    endtask

    task automatic send_packet(input byte_q_t bytes, input bit jit, input bit nostuff,
                               input int abort_byte, input int abort_kind);
        int ones;
        logic [7:0] cb;
        tx_line = LS_J;
        tx_bitn = 0;
        tx_jit  = jit;
        for (int i = 0; i < 7; i++) tx_bit(1'b0);
        tx_bit(1'b1);
        ones = 0;
        for (int n = 0; n < bytes.size(); n++) begin
            if (n == abort_byte) begin
                do_abort(abort_kind);
                return;
            end
            cb = bytes[n];
            for (int b = 0; b < 8; b++) begin
                tx_bit(cb[b]);
                if (cb[b]) ones++;
                else ones = 0;
                if (!nostuff && ones == 6) begin
                    tx_bit(1'b0);
                    ones = 0;
                end
            end
        end
        drive(LS_SE0, 8);
        drive(LS_J, 4);
    endtask

    task automatic run(input string name, input byte_q_t bytes, input bit jit,
                       input bit nostuff, input int abort_byte, input int abort_kind);
        exp_q.delete();
        log_q.delete();
        got_cnt = 0;
        err_cnt = 0;
        build_model(bytes, nostuff, abort_byte);
        send_packet(bytes, jit, nostuff, abort_byte, abort_kind);
        for (int i = 0; i < 64 && bus.busy !== 1'b0; i++) @(negedge clk48);
        chk({name, "_idle"}, 32'(bus.busy), 32'd0);
        drive(LS_J, 8);
        chk({name, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_got_count"}, 32'(got_cnt), 32'(exp_got));
        chk({name, "_err_count"}, 32'(err_cnt), 32'(exp_err));
        if (exp_got == 1) chk({name, "_length_held"}, 32'(bus.packet_length), 32'(exp_len));
    endtask

    byte_q_t pk;

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        d_p    = 1'b1;
        d_n    = 1'b0;
        repeat (3) @(negedge clk48);
        chk("rst_write", 32'(bus.buffer_write), 32'd0);
        chk("rst_addr", 32'(bus.buffer_address), 32'd0);
        chk("rst_value", bus.buffer_write_value, 32'd0);
        chk("rst_got", 32'(bus.got_packet), 32'd0);
        chk("rst_length", 32'(bus.packet_length), 32'd0);
        chk("rst_error", 32'(bus.packet_error), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        reset  = 1'b0;
        enable = 1'b1;
        drive(LS_J, 10);

        pk = '{8'h2D, 8'h00, 8'h10};
        run("t1", pk, 1'b0, 1'b0, -1, 0);
        chk("t1_nwrites", 32'(log_q.size()), 32'd1);
        chk("t1_word0", logv(0), 32'h0010002D);
        chk("t1_len", 32'(bus.packet_length), 32'd3);

        pk = '{8'hC3, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAB, 8'hCD};
        run("t2", pk, 1'b0, 1'b0, -1, 0);
        chk("t2_word0", logv(0), 32'h030201C3);
        chk("t2_word1", logv(1), 32'h07060504);
        chk("t2_word2", logv(2), 32'h00CDAB08);
        chk("t2_len", 32'(bus.packet_length), 32'd11);

        pk = '{8'hFF, 8'hFF};
        run("t3_stuffed", pk, 1'b0, 1'b0, -1, 0);
        chk("t3_word0", logv(0), 32'h0000FFFF);

        pk = '{8'h7F, 8'h7F};
        run("t3_seven_ones", pk, 1'b0, 1'b1, -1, 0);
        chk("t3_err_pulse", 32'(err_cnt), 32'd1);
        chk("t3_no_got", 32'(got_cnt), 32'd0);

        pk.delete();
        for (int i = 0; i < 64; i++) pk.push_back(8'(i * 37 + 5));
        run("t4_jitter", pk, 1'b1, 1'b0, -1, 0);
        chk("t4_nwrites", 32'(log_q.size()), 32'd16);
        chk("t4_len", 32'(bus.packet_length), 32'd64);

        pk.delete();
        for (int i = 0; i < 1025; i++) pk.push_back(8'(i));
        run("t5_overflow", pk, 1'b0, 1'b0, -1, 0);
        chk("t5_nwrites", 32'(log_q.size()), 32'd256);
        chk("t5_last_addr", (log_q.size() == 256) ? 32'(log_q[255].addr) : 32'hFFFF, 32'd255);
        chk("t5_err_pulse", 32'(err_cnt), 32'd1);

        pk = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        run("t6_reset", pk, 1'b0, 1'b0, 5, 0);
        pk = '{8'h2D, 8'h00, 8'h10};
        run("t6_after_reset", pk, 1'b0, 1'b0, -1, 0);
        chk("t6r_word0", logv(0), 32'h0010002D);

        pk = '{8'hC3, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        run("t6_enable", pk, 1'b0, 1'b0, 5, 1);
        pk = '{8'h2D, 8'h00, 8'h10};
        run("t6_after_enable", pk, 1'b0, 1'b0, -1, 0);
        chk("t6e_len", 32'(bus.packet_length), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
